// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// default data width and FSM state encoding.
package sar_search_pkg;

    localparam int SAR_N = 8;

    typedef logic [1:0] sar_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TEST   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/sar_search_if.sv
// Request/comparator/result bundle between the search controller (master)
// and the host plus external magnitude comparator (slave).
interface sar_search_if #(
    parameter int N = 8
);
    logic         start;
    logic         cmp_lesser;
    logic         cmp_greater;
    logic         cmp_equal;
    logic [N-1:0] trial;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         exact;
    logic         err;

    modport master (
        input  start, cmp_lesser, cmp_greater, cmp_equal,
        output trial, busy, done, result, exact, err
    );

    modport slave (
        output start, cmp_lesser, cmp_greater, cmp_equal,
        input  trial, busy, done, result, exact, err
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial values to a combinational
// comparator, resolves one bit per compare, and verifies the final value.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int N = SAR_N
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sar_search_if.master  bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    sar_state_t   r_state;
    logic [N-1:0] r_acc;
    logic [IW-1:0] r_idx;
    logic [N-1:0] r_trial;
    logic [N-1:0] r_result;
    logic         r_exact;
    logic         r_err;

    logic         w_onehot;
    logic [N-1:0] w_acc_next;
    logic [N-1:0] w_one;
    logic [N-1:0] w_next_bit;

    assign w_onehot   = $onehot({bus.cmp_lesser, bus.cmp_greater, bus.cmp_equal});
    assign w_acc_next = bus.cmp_lesser ? r_trial : r_acc;
    assign w_one      = N'(1);
    // Only consumed when r_idx > 0, so the wrap at r_idx == 0 is harmless.
    assign w_next_bit = w_one << (r_idx - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_idx    <= '0;
            r_trial  <= '0;
            r_result <= '0;
            r_exact  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_idx   <= IW'(N - 1);
                        r_trial <= w_one << (N - 1);
                        r_exact <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_TEST;
                    end
                end
                ST_TEST: begin
                    if (!w_onehot) begin
                        r_err    <= 1'b1;
                        r_exact  <= 1'b0;
                        r_result <= '0;
                        r_state  <= ST_DONE;
                    end else if (bus.cmp_equal) begin
                        r_result <= r_trial;
                        r_exact  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_idx == '0) begin
                            r_trial <= w_acc_next;
                            r_state <= ST_VERIFY;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_trial <= w_acc_next | w_next_bit;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (!w_onehot) begin
                        r_err    <= 1'b1;
                        r_exact  <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_result <= r_acc;
                        r_exact  <= bus.cmp_equal;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.trial  = r_trial;
    assign bus.busy   = (r_state == ST_TEST) || (r_state == ST_VERIFY);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;
    assign bus.exact  = r_exact;
    assign bus.err    = r_err;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator responder with fault
// injection, a binary-search reference model, table plus random searches.
module tb_sar_search;

    localparam int N = 8;

    logic clk;
    logic rst;

    sar_search_if #(.N(N)) bus ();

    sar_search #(.N(N)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    int tgt;
    int bad;
    int cmp_idx;
    int got_q[$];
    int exp_q[$];
    int res, ex, er, done_seen;

    // Comparator responder: trial on input a, target on input b.
    always_comb begin
        if (bad != 0 && cmp_idx == bad) begin
            bus.cmp_lesser  = 1'b1;
            bus.cmp_greater = 1'b1;
            bus.cmp_equal   = 1'b0;
        end else begin
            bus.cmp_lesser  = (int'(bus.trial) < tgt);
            bus.cmp_greater = (int'(bus.trial) > tgt);
            bus.cmp_equal   = (int'(bus.trial) == tgt);
        end
    end

    typedef struct {
        int target;
        int bad_at;
        bit restart;
        int exp_cmp;
        int exp_res;
        int exp_exact;
        int exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain binary search over [0, 2^N), one trial per bit.
    function automatic void model(input int t, input int bad_at);
        int acc;
        int tr;
        bit found;
        acc = 0;
        found = 0;
        exp_q.delete();
        for (int b = N - 1; b >= 0; b--) begin
            tr = acc + (1 << b);
            exp_q.push_back(tr);
            if (tr == t) begin
                found = 1;
                break;
            end
            if (tr < t) acc = tr;
        end
        if (!found) exp_q.push_back(acc);
        if (bad_at > 0) begin
            while (exp_q.size() > bad_at) void'(exp_q.pop_back());
        end
    endfunction

    task automatic run_search(input int target, input int bad_at, input bit restart);
        got_q.delete();
        tgt = target;
        bad = bad_at;
        cmp_idx = 0;
        done_seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        check("err_cleared", int'(bus.err), 0);
        check("exact_cleared", int'(bus.exact), 0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.busy) begin
                cmp_idx++;
                got_q.push_back(int'(bus.trial));
                if (restart && cmp_idx >= 2) bus.start = 1'b1;
                @(negedge clk);
            end else begin
                done_seen = int'(bus.done);
                break;
            end
        end
        check("done_reached", done_seen, 1);
        res = int'(bus.result);
        ex  = int'(bus.exact);
        er  = int'(bus.err);
        @(negedge clk);
        bus.start = 1'b0;
        check("done_single_pulse", int'(bus.done), 0);
        check("idle_after_done", int'(bus.busy), 0);
        check("result_held", int'(bus.result), res);
    endtask

    task automatic do_vec(input vec_t v);
        run_search(v.target, v.bad_at, v.restart);
        model(v.target, v.bad_at);
        check("compares", got_q.size(), v.exp_cmp);
        check("model_compares", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("trial_seq", got_q[i], exp_q[i]);
        check("result", res, v.exp_res);
        check("exact", ex, v.exp_exact);
        check("err", er, v.exp_err);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        vectors = 0;
        miscompares = 0;
        tgt = 0;
        bad = 0;
        cmp_idx = 0;
        bus.start = 1'b0;
        rst = 1'b1;

        tbl.push_back('{169, 0, 1'b0, 8, 169, 1, 0});
        tbl.push_back('{128, 0, 1'b0, 1, 128, 1, 0});
        tbl.push_back('{0,   0, 1'b0, 9, 0,   1, 0});
        tbl.push_back('{255, 0, 1'b0, 8, 255, 1, 0});
        tbl.push_back('{96,  3, 1'b0, 3, 0,   0, 1});
        tbl.push_back('{85,  0, 1'b1, 8, 85,  1, 0});
        tbl.push_back('{21,  0, 1'b0, 8, 21,  1, 0});
        tbl.push_back('{64,  0, 1'b0, 2, 64,  1, 0});
        tbl.push_back('{1,   0, 1'b0, 8, 1,   1, 0});

        repeat (2) @(negedge clk);
        check("rst_trial", int'(bus.trial), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_exact", int'(bus.exact), 0);
        check("rst_err", int'(bus.err), 0);
        rst = 1'b0;

        foreach (tbl[i]) do_vec(tbl[i]);

        // Reset in the middle of a search aborts without a done pulse.
        tgt = 199;
        bad = 0;
        cmp_idx = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (bus.busy) cmp_idx++;
            @(negedge clk);
        end
        check("mid_busy_before_rst", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_trial", int'(bus.trial), 0);
        check("mid_rst_result", int'(bus.result), 0);
        rst = 1'b0;
        do_vec('{199, 0, 1'b0, 8, 199, 1, 0});

        for (int k = 0; k < 30; k++) begin
            rv.target  = int'($urandom_range(0, 255));
            model(rv.target, 0);
            rv.bad_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, exp_q.size())) : 0;
            rv.restart = ($urandom_range(0, 4) == 0);
            rv.exp_cmp = (rv.bad_at != 0) ? rv.bad_at : exp_q.size();
            rv.exp_res   = (rv.bad_at != 0) ? 0 : rv.target;
            rv.exp_exact = (rv.bad_at != 0) ? 0 : 1;
            rv.exp_err   = (rv.bad_at != 0) ? 1 : 0;
            do_vec(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller: finds an unknown N-bit target by driving trial values to an external magnitude comparator and reading back its lesser/greater/equal flags.
- Acts as the initiator for the team's combinational comparator: `trial` feeds comparator input a, the target feeds input b, and the flags return here.
- Used for threshold search and value recovery wherever only a compare path to a value exists.

Parameters:
- N, 8, data width of trial, target and result

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a search; sampled only in IDLE
- cmp_lesser  input  1  comparator flag: trial < target
- cmp_greater  input  1  comparator flag: trial > target
- cmp_equal  input  1  comparator flag: trial == target
- trial  output  N  registered trial value to the comparator
- busy  output  1  high in TEST and VERIFY
- done  output  1  one-cycle pulse at search end
- result  output  N  found value; held from done until the next start
- exact  output  1  result confirmed equal by the comparator
- err  output  1  flag protocol violation on the last search

Behaviour:
- Reset: state=IDLE; trial, result, acc and bit index = 0; busy, done, exact, err = 0. Reset mid-search aborts immediately with no done pulse.
- Flags are sampled at each rising edge while state is TEST or VERIFY. The comparator is combinational, so flags for the current `trial` are valid in the same cycle.
- IDLE:
  - start=1 -> acc=0, idx=N-1, trial=1<<(N-1), state=TEST.
  - exact and err are cleared on start; result is unchanged.
- TEST (trial = acc | 1<<idx):
  - If flags are not exactly one-hot -> err=1, exact=0, result=0, state=DONE.
  - Else if equal -> result=trial, exact=1, state=DONE (early exit).
  - Else if lesser -> acc=trial.
  - Else (greater) -> acc unchanged.
  - Then, if idx==0 -> trial=new acc, state=VERIFY; else idx-=1 and trial=new acc | 1<<(idx-1).
- VERIFY (trial=acc):
  - One-hot violation -> err=1, result=0.
  - Equal -> result=acc, exact=1.
  - Otherwise -> result=acc, exact=0.
  - State=DONE in all cases.
- DONE: done=1 for exactly one cycle, busy=0, then state=IDLE. A start in the DONE cycle is ignored.
- start while busy is ignored. There is no queued request.
- Latency, for a consistent comparator:
  - Number of compares = N - (index of target's lowest set bit).
  - target=0 needs N+1 compares (reaches VERIFY).
  - done is asserted the cycle after the deciding compare.
- trial holds its last value in IDLE and DONE. Arithmetic is unsigned. acc never exceeds 2^N-1.

Decomposition:
- Shared package holds the state encoding (IDLE, TEST, VERIFY, DONE) and the default width constant N=8.
- No sub-module is needed: single FSM plus datapath registers.
- The bench instantiates the team comparator as the responder, with the target driven on its b input.

Test Plan:
- Target 169, start pulse -> trials 128,192,160,176,168,172,170,169. Equal on the 8th compare; done one cycle later; result=169, exact=1, err=0.
- Target 128 -> single trial 128 equal; done on the 2nd cycle after the start edge; result=128, exact=1.
- Target 0 -> trials 128,64,...,1 all greater, then VERIFY trial 0 equal; result=0, exact=1, done after 9 compares. Target 255 -> trials 128,192,...,254,255; equal on the 8th compare.
- Comparator model forces lesser=greater=1 on the 3rd compare of target 96 -> err=1, result=0, exact=0, single done pulse, then IDLE.
- start re-asserted during a busy search for 85 -> ignored; result=85 with exactly one done pulse. A fresh start with target 21 then yields 21.
- rst asserted mid-search (target 199, after 4 compares) -> next cycle: busy=0, done=0, trial=0, result=0. A new search for 199 completes normally.
